// File: rtl/reg_share_arb.sv
// Round-robin arbiter that lets one of four requesters load a shared register and then holds ownership for HOLD cycles.
// Optional grant counter output gnt_cnt is enabled by defining REG_SHARE_ARB_CNT_EN.
module reg_share_arb #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   din,
    output logic [3:0]           gnt,
    output logic [WIDTH-1:0]     q,
    output logic [1:0]           owner,
`ifdef REG_SHARE_ARB_CNT_EN
    output logic                 busy,
    output logic [7:0]           gnt_cnt
`else
    output logic                 busy
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               win_found;
    logic [1:0]         win_idx;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && req[ptr_q + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = 4'b0000;
        q_d     = q_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (win_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = 4'b0001 << win_idx;
                    q_d     = din[win_idx*WIDTH +: WIDTH];
                    owner_d = win_idx;
                    ptr_d   = win_idx;
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                if (HOLD > 0) begin
                    state_d = ST_HOLD;
                    cnt_d   = 4'(HOLD);
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_HOLD: begin
                // A count of 1 marks the final hold cycle.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            q_q     <= '0;
            owner_q <= 2'd0;
            ptr_q   <= 2'd3;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign busy  = busy_q;

`ifdef REG_SHARE_ARB_CNT_EN
    logic [7:0] gnt_cnt_q, gnt_cnt_d;

    always_comb begin
        gnt_cnt_d = gnt_cnt_q;
        if ((gnt_d != 4'b0000) && (gnt_cnt_q != 8'hFF)) begin
            gnt_cnt_d = gnt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_cnt_q <= 8'd0;
        end else begin
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign gnt_cnt = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_reg_share_arb.sv
// Bench for reg_share_arb: two instances (HOLD=2 and HOLD=0) share stimulus and are checked against a busy-time model.
module tb_reg_share_arb;

    localparam int W = 8;

    logic            clk;
    logic            reset;
    logic [3:0]      req;
    logic [4*W-1:0]  din;

    logic [3:0]      gnt_o   [2];
    logic [W-1:0]    q_o     [2];
    logic [1:0]      owner_o [2];
    logic            busy_o  [2];

    int n_tests;
    int n_fail;

    // Reference model: remaining busy cycles per instance instead of explicit states.
    int          m_rem   [2];
    int          m_ptr   [2];
    logic [3:0]  m_gnt   [2];
    logic [W-1:0] m_q    [2];
    logic [1:0]  m_owner [2];
    int          m_cnt   [2];

`ifdef REG_SHARE_ARB_CNT_EN
    logic [7:0]  cnt_o [2];

    reg_share_arb #(.WIDTH(W), .HOLD(2)) dut0 (
        .clk(clk), .reset(reset), .req(req), .din(din),
        .gnt(gnt_o[0]), .q(q_o[0]), .owner(owner_o[0]), .busy(busy_o[0]), .gnt_cnt(cnt_o[0])
    );
    reg_share_arb #(.WIDTH(W), .HOLD(0)) dut1 (
        .clk(clk), .reset(reset), .req(req), .din(din),
        .gnt(gnt_o[1]), .q(q_o[1]), .owner(owner_o[1]), .busy(busy_o[1]), .gnt_cnt(cnt_o[1])
    );
`else
    reg_share_arb #(.WIDTH(W), .HOLD(2)) dut0 (
        .clk(clk), .reset(reset), .req(req), .din(din),
        .gnt(gnt_o[0]), .q(q_o[0]), .owner(owner_o[0]), .busy(busy_o[0])
    );
    reg_share_arb #(.WIDTH(W), .HOLD(0)) dut1 (
        .clk(clk), .reset(reset), .req(req), .din(din),
        .gnt(gnt_o[1]), .q(q_o[1]), .owner(owner_o[1]), .busy(busy_o[1])
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rem[i]   = 0;
            m_ptr[i]   = 3;
            m_gnt[i]   = 4'b0000;
            m_q[i]     = '0;
            m_owner[i] = 2'd0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int hold;
            int w;
            hold = (i == 0) ? 2 : 0;
            m_gnt[i] = 4'b0000;
            if (m_rem[i] == 0 && req != 4'b0000) begin
                w = -1;
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_ptr[i] + k) % 4;
                    if (w < 0 && req[c]) w = c;
                end
                m_gnt[i]   = 4'(1 << w);
                m_q[i]     = din[w*W +: W];
                m_owner[i] = 2'(w);
                m_ptr[i]   = w;
                m_rem[i]   = hold + 1;
                if (m_cnt[i] < 255) m_cnt[i]++;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
            end
        end
    endtask

    // Advance one edge and leave the caller 1ns after it, safely away from the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #3;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b0000;
        din = '0;
        reset = 1'b1;
        model_reset();
        #3;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (gnt_o[i] !== 4'b0000 || q_o[i] !== 8'h00 || owner_o[i] !== 2'd0 || busy_o[i] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_state dut%0d: got gnt=%b q=%h owner=%0d busy=%b, expected all zero",
                         i, gnt_o[i], q_o[i], owner_o[i], busy_o[i]);
            end
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (gnt_o[i] !== 4'b0000 || busy_o[i] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL idle_no_req dut%0d: got gnt=%b busy=%b, expected 0000/0", i, gnt_o[i], busy_o[i]);
            end
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        req = 4'b0001;
        din = {8'h00, 8'h00, 8'h00, 8'hA5};
        tick();
        req = 4'b0000;
        n_tests++;
        if (gnt_o[0] !== 4'b0001 || q_o[0] !== 8'hA5 || owner_o[0] !== 2'd0 || busy_o[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got gnt=%b q=%h owner=%0d busy=%b, expected 0001/a5/0/1",
                     gnt_o[0], q_o[0], owner_o[0], busy_o[0]);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_tests++;
            if (busy_o[0] !== (c < 3) || gnt_o[0] !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL single_busy_c%0d: got busy=%b gnt=%b, expected busy=%b gnt=0000",
                         c, busy_o[0], gnt_o[0], (c < 3));
            end
        end
    endtask

    task automatic test_rotate();
        int          g_idx [$];
        int          g_cyc [$];
        int          exp_idx [5];
        logic [7:0]  words [4];
        exp_idx = '{0, 1, 2, 3, 0};
        words   = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        req = 4'b1111;
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (gnt_o[i] !== m_gnt[i] || q_o[i] !== m_q[i] || owner_o[i] !== m_owner[i] || busy_o[i] !== (m_rem[i] > 0)) begin
                    n_fail++;
                    $display("[TB] FAIL rotate_model dut%0d cyc%0d: got gnt=%b q=%h owner=%0d busy=%b, expected %b/%h/%0d/%b",
                             i, cyc, gnt_o[i], q_o[i], owner_o[i], busy_o[i], m_gnt[i], m_q[i], m_owner[i], (m_rem[i] > 0));
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (gnt_o[0][b]) begin
                    g_idx.push_back(b);
                    g_cyc.push_back(cyc);
                end
            end
        end
        n_tests++;
        if (g_idx.size() < 5) begin
            n_fail++;
            $display("[TB] FAIL rotate_count: got %0d grants, expected at least 5", g_idx.size());
        end else begin
            for (int n = 0; n < 5; n++) begin
                n_tests++;
                if (g_idx[n] != exp_idx[n] || (n > 0 && g_cyc[n] - g_cyc[n-1] != 4)) begin
                    n_fail++;
                    $display("[TB] FAIL rotate_order n%0d: got idx=%0d cyc=%0d, expected idx=%0d spacing 4",
                             n, g_idx[n], g_cyc[n], exp_idx[n]);
                end
            end
        end
        n_tests++;
        if (q_o[0] !== words[owner_o[0]]) begin
            n_fail++;
            $display("[TB] FAIL rotate_q: got %h, expected %h", q_o[0], words[owner_o[0]]);
        end
    endtask

    task automatic test_ignore_in_hold();
        do_reset();
        req = 4'b0001;
        din = {8'h00, 8'h77, 8'h00, 8'hA5};
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        for (int cyc = 0; cyc < 3; cyc++) begin
            n_tests++;
            if (gnt_o[0] !== 4'b0000 || q_o[0] !== 8'hA5 || owner_o[0] !== 2'd0) begin
                n_fail++;
                $display("[TB] FAIL hold_ignore cyc%0d: got gnt=%b q=%h owner=%0d, expected 0000/a5/0",
                         cyc, gnt_o[0], q_o[0], owner_o[0]);
            end
            n_tests++;
            if (gnt_o[1] !== m_gnt[1] || q_o[1] !== m_q[1] || busy_o[1] !== (m_rem[1] > 0)) begin
                n_fail++;
                $display("[TB] FAIL hold_ignore_h0 cyc%0d: got gnt=%b q=%h busy=%b, expected %b/%h/%b",
                         cyc, gnt_o[1], q_o[1], busy_o[1], m_gnt[1], m_q[1], (m_rem[1] > 0));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 4'b0100;
        din = {8'h00, 8'h5C, 8'h00, 8'h00};
        tick();
        req = 4'b0000;
        tick();
        reset = 1'b1;
        model_reset();
        #2;
        n_tests++;
        if (q_o[0] !== 8'h00 || busy_o[0] !== 1'b0 || owner_o[0] !== 2'd0 || gnt_o[0] !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_hold: got q=%h busy=%b owner=%0d gnt=%b, expected 00/0/0/0000",
                     q_o[0], busy_o[0], owner_o[0], gnt_o[0]);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (gnt_o[0] !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL no_carry_over: got gnt=%b, expected 0000", gnt_o[0]);
        end
        req = 4'b1100;
        din = {8'hD4, 8'hC3, 8'h00, 8'h00};
        tick();
        req = 4'b0000;
        n_tests++;
        if (gnt_o[0] !== 4'b0100 || owner_o[0] !== 2'd2 || q_o[0] !== 8'hC3) begin
            n_fail++;
            $display("[TB] FAIL post_reset_grant: got gnt=%b owner=%0d q=%h, expected 0100/2/c3",
                     gnt_o[0], owner_o[0], q_o[0]);
        end
    endtask

    task automatic test_hold_zero();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b0011;
        din = {8'h00, 8'h00, 8'hB2, 8'hB1};
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_g = (k % 2 != 0) ? 4'b0000 : (((k / 2) % 2 == 0) ? 4'b0001 : 4'b0010);
            n_tests++;
            if (gnt_o[1] !== exp_g || busy_o[1] !== (k % 2 == 0)) begin
                n_fail++;
                $display("[TB] FAIL hold_zero k%0d: got gnt=%b busy=%b, expected %b/%b",
                         k, gnt_o[1], busy_o[1], exp_g, (k % 2 == 0));
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = 4'b0000;
            din = $urandom();
            tick();
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (gnt_o[i] !== m_gnt[i] || q_o[i] !== m_q[i] || owner_o[i] !== m_owner[i] || busy_o[i] !== (m_rem[i] > 0)) begin
                    n_fail++;
                    $display("[TB] FAIL random dut%0d cyc%0d: got gnt=%b q=%h owner=%0d busy=%b, expected %b/%h/%0d/%b",
                             i, cyc, gnt_o[i], q_o[i], owner_o[i], busy_o[i], m_gnt[i], m_q[i], m_owner[i], (m_rem[i] > 0));
                end
            end
        end
        req = 4'b0000;
    endtask

`ifdef REG_SHARE_ARB_CNT_EN
    task automatic test_gnt_cnt();
        do_reset();
        req = 4'b1111;
        din = $urandom();
        for (int cyc = 0; cyc < 1300; cyc++) tick();
        req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (cnt_o[i] !== 8'(m_cnt[i]) || m_cnt[i] != 255) begin
                n_fail++;
                $display("[TB] FAIL gnt_cnt_sat dut%0d: got %0d, expected 255", i, cnt_o[i]);
            end
        end
        reset = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (cnt_o[i] !== 8'd0) begin
                n_fail++;
                $display("[TB] FAIL gnt_cnt_reset dut%0d: got %0d, expected 0", i, cnt_o[i]);
            end
        end
        reset = 1'b0;
        model_reset();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        req     = 4'b0000;
        din     = '0;
        model_reset();
        #2;
        test_reset();
        test_single_grant();
        test_rotate();
        test_ignore_in_hold();
        test_reset_mid_hold();
        test_hold_zero();
        test_random();
`ifdef REG_SHARE_ARB_CNT_EN
        test_gnt_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
